// File: rtl/v60_pkg.sv
// V60 shared types and constants.
// Prefetch FSM encoding and window/word sizes.
`include "v60_defines.sv"
package v60_pkg;
  typedef enum logic [1:0] {
    PF_IDLE,
    PF_REQ,
    PF_DRAIN
  } pf_state_t;

  localparam int V60_PF_WINDOW_BYTES = 6;
  localparam int V60_PF_WORD_BYTES   = 4;
endpackage

// File: rtl/v60_byte_ring.sv
// DEPTH-byte circular store for the V60 prefetch queue.
// Writes up to 4 bytes with a leading skip, pops 0-6 bytes.
module v60_byte_ring
  import v60_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_wr_en,
  input  logic [31:0]   i_wr_data,
  input  logic [1:0]    i_wr_skip,
  input  logic [2:0]    i_pop_len,
  output logic [CW-1:0] o_count,
  output logic [CW-1:0] o_count_nxt,
  output logic [47:0]   o_window
);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [2:0]    w_nwr;
  logic [31:0]   w_shift;

  assign w_nwr = i_wr_en ? (3'd4 - {1'b0, i_wr_skip}) : 3'd0;
  assign w_shift = i_wr_data >> {i_wr_skip, 3'b000};
  assign o_count_nxt = i_clr ? '0 :
    r_count - CW'(i_pop_len) + CW'(w_nwr);
  assign o_count = r_count;

  // Payload needs no reset: the window masks bytes beyond count.
  always_ff @(posedge clk) begin
    for (int k = 0; k < V60_PF_WORD_BYTES; k++) begin
      if (!i_clr && (3'(k) < w_nwr))
        r_mem[r_wr_ptr + AW'(k)] <= w_shift[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + AW'(i_pop_len);
      r_wr_ptr <= r_wr_ptr + AW'(w_nwr);
      r_count  <= o_count_nxt;
    end
  end

  always_comb begin
    o_window = '0;
    for (int i = 0; i < V60_PF_WINDOW_BYTES; i++) begin
      if (CW'(i) < r_count)
        o_window[8*i +: 8] = r_mem[r_rd_ptr + AW'(i)];
    end
  end
endmodule

// File: rtl/v60_defines.sv
// V60 global widths shared by the CPU front end.
// Guarded so every file may include it.
`ifndef V60_DEFINES_SV
`define V60_DEFINES_SV
`define V60_ADDR_WIDTH 32
`define V60_DATA_WIDTH 32
`endif

// File: rtl/v60_prefetch_queue.sv
// V60 instruction prefetch queue: word fetch FSM plus byte ring.
// Define V60_PREFETCH_PERF_EN to add perf_* counters.
`include "v60_defines.sv"
module v60_prefetch_queue
  import v60_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       mem_req,
  output logic [`V60_ADDR_WIDTH-1:0] mem_addr,
  input  logic [`V60_DATA_WIDTH-1:0] mem_rdata,
  input  logic                       mem_ready,
  input  logic                       flush,
  input  logic [31:0]                flush_addr,
  input  logic                       consume,
  input  logic [2:0]                 consume_len,
  output logic [47:0]                q_data,
  output logic [CW-1:0]              q_count,
  output logic [31:0]                q_pc
`ifdef V60_PREFETCH_PERF_EN
  ,
  output logic [31:0]                perf_fetches,
  output logic [31:0]                perf_flushes,
  output logic [31:0]                perf_empty_cycles
`endif
);
  localparam logic [`V60_ADDR_WIDTH-1:0] RST_ADDR =
    `V60_ADDR_WIDTH'(RESET_PC & ~32'h3);

  pf_state_t r_state, w_state_nxt;
  logic [`V60_ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [`V60_ADDR_WIDTH-1:0] r_pend, w_pend_nxt;
  logic [`V60_ADDR_WIDTH-1:0] w_flush_aln;
  logic [1:0]    r_skip, w_skip_nxt;
  logic [31:0]   r_pc;
  logic          w_pop_ok;
  logic [2:0]    w_pop_len;
  logic          w_wr_en;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_free;
  logic          w_room;

  assign w_pop_ok = consume && (consume_len != 3'd0) &&
    (consume_len <= 3'(V60_PF_WINDOW_BYTES)) &&
    (CW'(consume_len) <= q_count);
  assign w_pop_len = (w_pop_ok && !flush) ? consume_len : 3'd0;
  assign w_wr_en = (r_state == PF_REQ) && mem_ready && !flush;
  assign w_flush_aln = `V60_ADDR_WIDTH'({flush_addr[31:2], 2'b00});
  assign w_free = CW'(DEPTH) - w_cnt_nxt;
  assign w_room = w_free >= CW'(V60_PF_WORD_BYTES);

  v60_byte_ring #(.DEPTH(DEPTH)) u_ring (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (flush),
    .i_wr_en     (w_wr_en),
    .i_wr_data   (mem_rdata),
    .i_wr_skip   (r_skip),
    .i_pop_len   (w_pop_len),
    .o_count     (q_count),
    .o_count_nxt (w_cnt_nxt),
    .o_window    (q_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_pend_nxt  = r_pend;
    w_skip_nxt  = r_skip;
    unique case (r_state)
      PF_IDLE: begin
        if (flush) begin
          w_addr_nxt  = w_flush_aln;
          w_skip_nxt  = flush_addr[1:0];
          w_state_nxt = PF_REQ;
        end else if (w_room) begin
          w_state_nxt = PF_REQ;
        end
      end
      PF_REQ: begin
        if (flush) begin
          w_skip_nxt = flush_addr[1:0];
          if (mem_ready) begin
            w_addr_nxt = w_flush_aln;
          end else begin
            w_pend_nxt  = w_flush_aln;
            w_state_nxt = PF_DRAIN;
          end
        end else if (mem_ready) begin
          w_addr_nxt  = r_addr + `V60_ADDR_WIDTH'(V60_PF_WORD_BYTES);
          w_skip_nxt  = 2'b00;
          w_state_nxt = w_room ? PF_REQ : PF_IDLE;
        end
      end
      PF_DRAIN: begin
        // The old request stays on the bus; only the target moves.
        if (flush) begin
          w_pend_nxt = w_flush_aln;
          w_skip_nxt = flush_addr[1:0];
        end
        if (mem_ready) begin
          w_addr_nxt  = flush ? w_flush_aln : r_pend;
          w_state_nxt = PF_REQ;
        end
      end
      default: w_state_nxt = PF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PF_IDLE;
      r_addr  <= RST_ADDR;
      r_pend  <= RST_ADDR;
      r_skip  <= RESET_PC[1:0];
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_pend  <= w_pend_nxt;
      r_skip  <= w_skip_nxt;
      if (flush)
        r_pc <= flush_addr;
      else
        r_pc <= r_pc + 32'(w_pop_len);
    end
  end

  assign mem_req  = (r_state != PF_IDLE);
  assign mem_addr = r_addr;
  assign q_pc     = r_pc;

`ifdef V60_PREFETCH_PERF_EN
  logic [31:0] r_perf_fetches;
  logic [31:0] r_perf_flushes;
  logic [31:0] r_perf_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetches <= '0;
      r_perf_flushes <= '0;
      r_perf_empty   <= '0;
    end else begin
      r_perf_fetches <= r_perf_fetches + 32'(w_wr_en);
      r_perf_flushes <= r_perf_flushes + 32'(flush);
      r_perf_empty   <= r_perf_empty + 32'(q_count == '0);
    end
  end

  assign perf_fetches      = r_perf_fetches;
  assign perf_flushes      = r_perf_flushes;
  assign perf_empty_cycles = r_perf_empty;
`endif
endmodule

// File: tb/tb_v60_prefetch_queue.sv
// Directed bench for v60_prefetch_queue: vector table plus
// hand sequences for flush, drain and same-cycle pop/write.
module tb_v60_prefetch_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        flush;
  logic [31:0] flush_addr;
  logic        consume;
  logic [2:0]  consume_len;
  logic [47:0] q_data;
  logic [4:0]  q_count;
  logic [31:0] q_pc;
`ifdef V60_PREFETCH_PERF_EN
  logic [31:0] perf_fetches;
  logic [31:0] perf_flushes;
  logic [31:0] perf_empty_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] b;
    if (a == 32'h1000) return 32'hDDCC_BBAA;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  assign mem_rdata = word_at(mem_addr);

  v60_prefetch_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .flush       (flush),
    .flush_addr  (flush_addr),
    .consume     (consume),
    .consume_len (consume_len),
    .q_data      (q_data),
    .q_count     (q_count),
    .q_pc        (q_pc)
`ifdef V60_PREFETCH_PERF_EN
    ,
    .perf_fetches      (perf_fetches),
    .perf_flushes      (perf_flushes),
    .perf_empty_cycles (perf_empty_cycles)
`endif
  );

  typedef struct {
    logic        cons;
    logic [2:0]  len;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic [4:0]  e_cnt;
    logic [31:0] e_pc;
    logic [47:0] e_data;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_req,
                           input logic [31:0] e_addr,
                           input logic [4:0] e_cnt,
                           input logic [31:0] e_pc,
                           input logic [47:0] e_data);
    chk({tag, "_req"}, 64'(mem_req), 64'(e_req));
    chk({tag, "_addr"}, 64'(mem_addr), 64'(e_addr));
    chk({tag, "_cnt"}, 64'(q_count), 64'(e_cnt));
    chk({tag, "_pc"}, 64'(q_pc), 64'(e_pc));
    chk({tag, "_data"}, 64'(q_data), 64'(e_data));
  endtask

  task automatic drive(input logic c, input logic [2:0] l,
                       input logic f, input logic [31:0] fa,
                       input logic r);
    consume     = c;
    consume_len = l;
    flush       = f;
    flush_addr  = fa;
    mem_ready   = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 3'd0, 1'b1, 1'b1, 32'd0,  5'd0,  32'd0,
                48'h0};
    tbl[1]  = '{1'b0, 3'd0, 1'b1, 1'b1, 32'd4,  5'd4,  32'd0,
                48'h0000_0302_0100};
    tbl[2]  = '{1'b0, 3'd0, 1'b1, 1'b1, 32'd8,  5'd8,  32'd0,
                48'h0504_0302_0100};
    tbl[3]  = '{1'b0, 3'd0, 1'b1, 1'b1, 32'd12, 5'd12, 32'd0,
                48'h0504_0302_0100};
    tbl[4]  = '{1'b0, 3'd0, 1'b1, 1'b0, 32'd16, 5'd16, 32'd0,
                48'h0504_0302_0100};
    tbl[5]  = '{1'b0, 3'd0, 1'b1, 1'b0, 32'd16, 5'd16, 32'd0,
                48'h0504_0302_0100};
    tbl[6]  = '{1'b1, 3'd6, 1'b0, 1'b1, 32'd16, 5'd10, 32'd6,
                48'h0b0a_0908_0706};
    tbl[7]  = '{1'b1, 3'd3, 1'b0, 1'b1, 32'd16, 5'd7,  32'd9,
                48'h0e0d_0c0b_0a09};
    tbl[8]  = '{1'b0, 3'd0, 1'b1, 1'b1, 32'd20, 5'd11, 32'd9,
                48'h0e0d_0c0b_0a09};
    tbl[9]  = '{1'b0, 3'd0, 1'b1, 1'b0, 32'd24, 5'd15, 32'd9,
                48'h0e0d_0c0b_0a09};
    tbl[10] = '{1'b1, 3'd7, 1'b0, 1'b0, 32'd24, 5'd15, 32'd9,
                48'h0e0d_0c0b_0a09};
    tbl[11] = '{1'b1, 3'd0, 1'b0, 1'b0, 32'd24, 5'd15, 32'd9,
                48'h0e0d_0c0b_0a09};
    tbl[12] = '{1'b1, 3'd5, 1'b0, 1'b1, 32'd24, 5'd10, 32'd14,
                48'h1312_1110_0f0e};

    rst_n = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 32'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 32'd0, 5'd0, 32'd0, 48'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].cons, tbl[i].len, 1'b0, 32'd0, tbl[i].rdy);
      step();
      check_all($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_addr,
                tbl[i].e_cnt, tbl[i].e_pc, tbl[i].e_data);
    end

    drive(1'b0, 3'd0, 1'b1, 32'h1002, 1'b1);
    step();
    check_all("fl_a0", 1'b1, 32'h1000, 5'd0, 32'h1002, 48'h0);
    drive(1'b0, 3'd0, 1'b0, 32'd0, 1'b1);
    step();
    check_all("fl_a1", 1'b1, 32'h1004, 5'd2, 32'h1002, 48'hDDCC);

    drive(1'b0, 3'd0, 1'b1, 32'h20, 1'b0);
    step();
    check_all("dr_b1", 1'b1, 32'h1004, 5'd0, 32'h20, 48'h0);
    drive(1'b0, 3'd0, 1'b0, 32'd0, 1'b1);
    step();
    check_all("dr_b2", 1'b1, 32'h20, 5'd0, 32'h20, 48'h0);
    drive(1'b0, 3'd0, 1'b1, 32'h40, 1'b0);
    step();
    check_all("dr_b3", 1'b1, 32'h20, 5'd0, 32'h40, 48'h0);
    drive(1'b0, 3'd0, 1'b1, 32'h41, 1'b0);
    step();
    check_all("dr_b4", 1'b1, 32'h20, 5'd0, 32'h41, 48'h0);
    drive(1'b0, 3'd0, 1'b0, 32'd0, 1'b0);
    step();
    check_all("dr_b5", 1'b1, 32'h20, 5'd0, 32'h41, 48'h0);
    drive(1'b0, 3'd0, 1'b0, 32'd0, 1'b1);
    step();
    check_all("dr_b6", 1'b1, 32'h40, 5'd0, 32'h41, 48'h0);
    step();
    check_all("dr_b7", 1'b1, 32'h44, 5'd3, 32'h41, 48'h43_4241);

    drive(1'b1, 3'd5, 1'b0, 32'd0, 1'b0);
    step();
    check_all("ill_b8", 1'b1, 32'h44, 5'd3, 32'h41, 48'h43_4241);
    drive(1'b1, 3'd3, 1'b0, 32'd0, 1'b1);
    step();
    check_all("pw_b9", 1'b1, 32'h48, 5'd4, 32'h44, 48'h4746_4544);
    drive(1'b0, 3'd0, 1'b0, 32'd0, 1'b1);
    step();
    check_all("pw_b10", 1'b1, 32'h4C, 5'd8, 32'h44,
              48'h4948_4746_4544);
    drive(1'b1, 3'd4, 1'b0, 32'd0, 1'b1);
    step();
    check_all("pw_b11", 1'b1, 32'h50, 5'd8, 32'h48,
              48'h4d4c_4b4a_4948);
    drive(1'b0, 3'd0, 1'b0, 32'd0, 1'b0);

`ifdef V60_PREFETCH_PERF_EN
    chk("perf_flushes", 64'(perf_flushes), 64'd4);
    chk("perf_fetches", 64'(perf_fetches), 64'd11);
`endif

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 64'(mem_req), 64'd0);
    chk("arst_addr", 64'(mem_addr), 64'd0);
    chk("arst_cnt", 64'(q_count), 64'd0);
    chk("arst_pc", 64'(q_pc), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
